pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_md_busy_cnt.sv | 54 +++++
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared constants for the pipeline controller: PC-select encodings, FSM state
//   encodings and default parameter values for the mult/div busy timing and
//   the exception entry address.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // PC mux select
  localparam logic [1:0] PC_SEL_SEQ     = 2'b00;  // sequential / branch target
  localparam logic [1:0] PC_SEL_HANDLER = 2'b01;  // exception handler entry
  localparam logic [1:0] PC_SEL_EPC     = 2'b10;  // return address from EPC

  // Controller FSM states
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_EXC = 2'd1;
  localparam logic [1:0] ST_RET = 2'd2;

  // Defaults
  localparam int unsigned MULT_CYC_DEF   = 5;
  localparam int unsigned DIV_CYC_DEF    = 10;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

endpackage

// File: rtl/pipe_ctrl_md_busy_cnt.sv
// -----------------------------------------------------------------------------
// md_busy_cnt
//   Tracks occupancy of the iterative multiply/divide unit. A load sets the
//   down-counter to MULT_CYC or DIV_CYC; busy_o is high while it is non-zero.
//   The counter saturates at zero. A load while busy simply reloads.
//
// Ports
//   clk     in   clock
//   reset   in   synchronous active-high reset (clears the counter)
//   load_i  in   start a new operation this cycle
//   div_i   in   qualifies load_i: 1 = divide, 0 = multiply
//   busy_o  out  unit occupied (registered)
// -----------------------------------------------------------------------------
module md_busy_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  localparam int unsigned MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: default assignment first so every path writes cnt_d; no latch.
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//   Pipeline controller: pipe-register enables/clears, PC select, mult/div
//   interlock and a small RUN/EXC/RET FSM that squashes the W slot the cycle
//   after an exception or eret redirect.
//
// Priority each cycle: exc_m > eret_m (RUN only) > stall > normal.
// During reset all combinational outputs take the normal (run) values.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   hz_stall_d  in   data-hazard stall from D-stage hazard logic
//   md_start_e  in   mult/div instruction in E
//   md_div_e    in   1 = divide, 0 = multiply (with md_start_e)
//   md_use_d    in   D-stage instruction needs the mult/div unit or HI/LO
//   exc_m       in   exception / interrupt taken at M
//   eret_m      in   eret at M
//   en_pc/en_d  out  PC and D-pipe write enables
//   clr_d/e/m/w out  synchronous pipe-register clears
//   pc_sel      out  PC mux select (see pipe_ctrl_pkg)
//   md_busy     out  mult/div unit occupied
//   state       out  FSM state (debug)
//   stall_cnt   out  stall cycle count   (only with PIPE_CTRL_PERF_EN)
//   flush_cnt   out  flush request count (only with PIPE_CTRL_PERF_EN)
//
// Build option: define PIPE_CTRL_PERF_EN to add the 32-bit perf counters.
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYC   = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC    = DIV_CYC_DEF,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hz_stall_d,
  input  logic        md_start_e,
  input  logic        md_div_e,
  input  logic        md_use_d,
  input  logic        exc_m,
  input  logic        eret_m,
  output logic        en_pc,
  output logic        en_d,
  output logic        clr_d,
  output logic        clr_e,
  output logic        clr_m,
  output logic        clr_w,
  output logic [1:0]  pc_sel,
  output logic        md_busy,
  output logic [1:0]  state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // The handler address itself is muxed in the fetch stage; the controller only
  // selects it. Kept as a parameter so both agree on one definition.
  logic unused_handler_pc;
  assign unused_handler_pc = ^HANDLER_PC;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       stall;

  // A flushed multiply/divide must not occupy the unit.
  md_busy_cnt #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_busy_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (md_start_e & ~exc_m),
    .div_i  (md_div_e),
    .busy_o (md_busy)
  );

  // md_start_e is included so the D instruction waits even in the issue cycle,
  // before the counter has been loaded.
  assign stall = hz_stall_d | (md_use_d & (md_busy | md_start_e));

  always_comb begin
    en_pc   = 1'b1;
    en_d    = 1'b1;
    clr_d   = 1'b0;
    clr_e   = 1'b0;
    clr_m   = 1'b0;
    clr_w   = 1'b0;
    pc_sel  = PC_SEL_SEQ;
    state_d = ST_RUN;   // EXC and RET always fall back to RUN
    if (!reset) begin
      // The M slot flushed by last cycle's redirect now sits in W.
      clr_w = (state_q != ST_RUN);
      if (exc_m) begin
        clr_d   = 1'b1;
        clr_e   = 1'b1;
        clr_m   = 1'b1;
        pc_sel  = PC_SEL_HANDLER;
        state_d = ST_EXC;
      end else if (eret_m && (state_q == ST_RUN)) begin
        clr_d   = 1'b1;
        clr_e   = 1'b1;
        pc_sel  = PC_SEL_EPC;
        state_d = ST_RET;
      end else if (stall) begin
        en_pc = 1'b0;
        en_d  = 1'b0;
        clr_e = 1'b1;   // bubble into E while D holds
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall)           stall_cnt_q <= stall_cnt_q + 32'd1;
      if (exc_m | eret_m)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
//   Self-checking bench for pipe_ctrl: single-cycle vector table, hand-written
//   multi-cycle sequences, and randomized traffic against a reference model.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       hz_stall_d, md_start_e, md_div_e, md_use_d, exc_m, eret_m;
  logic       en_pc, en_d, clr_d, clr_e, clr_m, clr_w, md_busy;
  logic [1:0] pc_sel, state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hz_stall_d (hz_stall_d),
    .md_start_e (md_start_e),
    .md_div_e   (md_div_e),
    .md_use_d   (md_use_d),
    .exc_m      (exc_m),
    .eret_m     (eret_m),
    .en_pc      (en_pc),
    .en_d       (en_d),
    .clr_d      (clr_d),
    .clr_e      (clr_e),
    .clr_m      (clr_m),
    .clr_w      (clr_w),
    .pc_sel     (pc_sel),
    .md_busy    (md_busy),
    .state      (state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, hz, st, dv, us, ex, er);
    reset = r; hz_stall_d = hz; md_start_e = st; md_div_e = dv;
    md_use_d = us; exc_m = ex; eret_m = er;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // {en_pc, en_d, clr_d, clr_e, clr_m, clr_w, pc_sel}
  function automatic logic [7:0] ctl();
    return {en_pc, en_d, clr_d, clr_e, clr_m, clr_w, pc_sel};
  endfunction

  typedef struct {
    logic       rst, hz, st, dv, us, ex, er;
    logic [7:0] exp;
    string      name;
  } vec_t;

  // ---------------- reference model (cycle-level behaviour) ----------------
  int m_left;      // cycles the mult/div unit stays occupied
  int m_last;      // redirect taken last cycle: 0 none, 1 exception, 2 eret

  function automatic logic [11:0] model_out(input logic r, hz, st, us, ex, er);
    bit busy, stl, exc_take, ret_take, flush;
    logic [7:0] c;
    busy     = (m_left > 0);
    stl      = hz || (us && (busy || st));
    exc_take = ex;
    ret_take = !ex && er && (m_last == 0);
    flush    = exc_take || ret_take;
    if (r) c = 8'b1100_0000;
    else begin
      c[7]   = flush || !stl;
      c[6]   = flush || !stl;
      c[5]   = flush;
      c[4]   = flush || stl;
      c[3]   = exc_take;
      c[2]   = (m_last != 0);
      c[1:0] = exc_take ? 2'd1 : (ret_take ? 2'd2 : 2'd0);
    end
    return {c, busy, 1'b0, 2'(m_last)};
  endfunction

  task automatic model_step(input logic r, st, dv, ex, er);
    int next_last;
    next_last = ex ? 1 : ((er && m_last == 0) ? 2 : 0);
    if (r) begin
      m_left = 0;
      m_last = 0;
    end else begin
      if (st && !ex)       m_left = dv ? DIV : MULT;
      else if (m_left > 0) m_left = m_left - 1;
      m_last = next_last;
    end
  endtask

  initial begin
    vec_t vecs[11];
    int   stalled;

    vecs[0]  = '{0,0,0,0,0,0,0, 8'b1100_0000, "idle"};
    vecs[1]  = '{0,1,0,0,0,0,0, 8'b0001_0000, "hazard_stall"};
    vecs[2]  = '{0,0,0,0,1,0,0, 8'b1100_0000, "use_not_busy"};
    vecs[3]  = '{0,0,1,0,1,0,0, 8'b0001_0000, "use_at_issue"};
    vecs[4]  = '{0,0,1,1,0,0,0, 8'b1100_0000, "div_issue_no_use"};
    vecs[5]  = '{0,0,0,0,0,1,0, 8'b1111_1001, "exception"};
    vecs[6]  = '{0,0,0,0,0,0,1, 8'b1111_0010, "eret"};
    vecs[7]  = '{0,0,0,0,0,1,1, 8'b1111_1001, "exc_over_eret"};
    vecs[8]  = '{0,1,0,0,0,0,1, 8'b1111_0010, "eret_over_stall"};
    vecs[9]  = '{0,0,1,0,1,1,0, 8'b1111_1001, "exc_over_md_stall"};
    vecs[10] = '{1,1,0,0,0,1,0, 8'b1100_0000, "normal_in_reset"};

    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    #1;
    check("reset_ctl",   32'(ctl()),   32'h0C0);
    check("reset_state", 32'(state),   32'd0);
    check("reset_busy",  32'(md_busy), 32'd0);

    // ---------------- single-cycle vector table ----------------
    for (int i = 0; i < 11; i++) begin
      do_reset();
      drive(vecs[i].rst, vecs[i].hz, vecs[i].st, vecs[i].dv, vecs[i].us, vecs[i].ex, vecs[i].er);
      #1;
      check(vecs[i].name, 32'(ctl()), 32'(vecs[i].exp));
      tick();
    end

    // ---------------- multiply interlock: 5 stalls then release ----------------
    do_reset();
    drive(0, 0, 1, 0, 0, 0, 0);
    #1;
    check("mul_issue_en_pc", 32'(en_pc), 32'd1);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    stalled = 0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c <= 5) check("mul_stall_en_pc", 32'(en_pc), 32'd0);
      else        check("mul_release_en_pc", 32'(en_pc), 32'd1);
      if (!en_pc) stalled++;
      tick();
    end
    check("mul_stall_count", 32'(stalled), 32'd5);

    // ---------------- divide aborted by reset ----------------
    do_reset();
    drive(0, 0, 1, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    reset = 1'b1;               // cycle 3
    #1;
    check("div_rst_en_pc", 32'(en_pc), 32'd1);
    tick();
    reset = 1'b0;               // cycle 4
    #1;
    check("div_rst_busy",  32'(md_busy), 32'd0);
    check("div_rst_en_pc4", 32'(en_pc),  32'd1);

    // ---------------- exception during a hazard stall ----------------
    do_reset();
    drive(0, 1, 0, 0, 0, 1, 0);
    #1;
    check("exc_ctl", 32'(ctl()), 32'hF9);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("exc_state", 32'(state), 32'd1);
    check("exc_clr_w", 32'(clr_w), 32'd1);
    tick();
    #1;
    check("exc_back_run", 32'(state), 32'd0);
    check("exc_clr_w_off", 32'(clr_w), 32'd0);

    // ---------------- eret, repeated eret ignored in RET ----------------
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("eret_ctl", 32'(ctl()), 32'hF2);
    tick();
    #1;                          // eret_m still high
    check("ret_state", 32'(state), 32'd2);
    check("ret_ctl_ignored", 32'(ctl()), 32'hC4);
    tick();
    eret_m = 1'b0;
    #1;
    check("ret_back_run", 32'(state), 32'd0);

    // ---------------- flushed multiply does not start the unit ----------------
    do_reset();
    drive(0, 0, 1, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("flushed_mul_busy", 32'(md_busy), 32'd0);

`ifdef PIPE_CTRL_PERF_EN
    // ---------------- performance counters ----------------
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_flush_cnt", flush_cnt, 32'd1);
`endif

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_left = 0;
    m_last = 0;
    for (int n = 0; n < 600; n++) begin
      logic r, hz, st, dv, us, ex, er;
      logic [11:0] exp_v;
      r  = ($urandom_range(0, 39) == 0);
      hz = ($urandom_range(0, 4)  == 0);
      st = ($urandom_range(0, 5)  == 0);
      dv = $urandom_range(0, 1) != 0;
      us = ($urandom_range(0, 2)  == 0);
      ex = ($urandom_range(0, 11) == 0);
      er = ($urandom_range(0, 9)  == 0);
      drive(r, hz, st, dv, us, ex, er);
      #1;
      exp_v = model_out(r, hz, st, us, ex, er);
      check("random_cycle", 32'({ctl(), md_busy, 1'b0, state}), 32'(exp_v));
      model_step(r, st, dv, ex, er);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
